// File: rtl/regwr_pkg.sv
// Shared constants and grant encoding for the register-file write-port arbiter.
package regwr_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT0     = 2'b01,
        GNT1     = 2'b10
    } gnt_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A zero-width counter is not legal, so MAX_WAIT=0 still gets one bit.
    function automatic int wait_width(input int max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/mux2x5.sv
// 5-bit 2:1 select used for the rt/rd-style register destination choice.
module mux2x5 (
    input  logic [4:0] d0,
    input  logic [4:0] d1,
    input  logic       s,
    output logic [4:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/regwr_wait_ctr.sv
// Saturating wait counter that tracks how long the long-latency source has been refused.
module regwr_wait_ctr
    import regwr_pkg::*;
#(
    parameter int MAX = 3,
    parameter int W   = wait_width(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign sat = (cnt >= MAX_V);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// Arbitrates the single register-file write port between the main writeback and the
// long-latency unit: fixed priority to req0, with req1 forced through after MAX_WAIT refusals.
module regwrite_arbiter
    import regwr_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 3,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          v0,
    input  logic [AW-1:0] a0,
    input  logic [DW-1:0] d0,
    output logic          rdy0,
    input  logic          v1,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] d1,
    output logic          rdy1,
    output logic          we,
    output logic [AW-1:0] wn,
    output logic [DW-1:0] wd,
    output logic          s,
    output logic [CW-1:0] conflicts
);

    localparam int WCW = wait_width(MAX_WAIT);

    // Handshake: a source transfers on any cycle where its v and rdy are both high;
    // rdy is combinational from this cycle's v0/v1 and the wait count, and is low in reset.
    gnt_t           gnt;
    logic           sel;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_data;
    logic [WCW-1:0] wait_cnt;
    logic           wait_sat;

    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (v0 && (!v1 || !wait_sat)) begin
                gnt = GNT0;
            end else if (v1) begin
                gnt = GNT1;
            end
        end
    end

    assign rdy0 = (gnt == GNT0);
    assign rdy1 = (gnt == GNT1);
    assign sel  = (gnt == GNT1);

    regwr_wait_ctr #(
        .MAX (MAX_WAIT),
        .W   (WCW)
    ) u_wait_ctr (
        .clk (clk),
        .rst (rst),
        .clr (rdy1 || !v1),
        .inc (v1 && !rdy1),
        .cnt (wait_cnt),
        .sat (wait_sat)
    );

    generate
        if (AW == 5) begin : g_addr_mux
            mux2x5 u_addr_mux (
                .d0 (a0),
                .d1 (a1),
                .s  (sel),
                .y  (sel_addr)
            );
        end else begin : g_addr_sel
            assign sel_addr = sel ? a1 : a0;
        end
    endgenerate

    assign sel_data = sel ? d1 : d0;

    // Writes to R0 still complete the handshake and update wn/wd/s; only we is held low.
    always_ff @(posedge clk) begin
        if (rst) begin
            we <= 1'b0;
            wn <= '0;
            wd <= '0;
            s  <= 1'b0;
        end else if (gnt != GNT_NONE) begin
            we <= (sel_addr != AW'(REG_ZERO));
            wn <= sel_addr;
            wd <= sel_data;
            s  <= sel;
        end else begin
            we <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflicts <= '0;
        end else if (v0 && v1 && (conflicts != {CW{1'b1}})) begin
            conflicts <= conflicts + 1'b1;
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed vector table, conflict-counter saturation and
// random hold/withdraw traffic, checked against a request-level model of two builds.
module tb_regwrite_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int CONF_MAX = 65535;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    logic          rdy0_o [2];
    logic          rdy1_o [2];
    logic          we_o   [2];
    logic [AW-1:0] wn_o   [2];
    logic [DW-1:0] wd_o   [2];
    logic          s_o    [2];
    logic [CW-1:0] conf_o [2];

    regwrite_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(3), .CW(CW)) u_dut (
        .clk(clk), .rst(rst),
        .v0(v0), .a0(a0), .d0(d0), .rdy0(rdy0_o[0]),
        .v1(v1), .a1(a1), .d1(d1), .rdy1(rdy1_o[0]),
        .we(we_o[0]), .wn(wn_o[0]), .wd(wd_o[0]), .s(s_o[0]), .conflicts(conf_o[0])
    );

    regwrite_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(0), .CW(CW)) u_dut_mw0 (
        .clk(clk), .rst(rst),
        .v0(v0), .a0(a0), .d0(d0), .rdy0(rdy0_o[1]),
        .v1(v1), .a1(a1), .d1(d1), .rdy1(rdy1_o[1]),
        .we(we_o[1]), .wn(wn_o[1]), .wd(wd_o[1]), .s(s_o[1]), .conflicts(conf_o[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per build, how many consecutive cycles req1 has been refused,
    // the last committed write, and the conflict tally.
    int            mw      [2] = '{3, 0};
    int            m_wait  [2];
    int            m_conf  [2];
    logic          m_we    [2];
    logic [AW-1:0] m_wn    [2];
    logic [DW-1:0] m_wd    [2];
    logic          m_s     [2];
    int            last_g;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    rf_model [32];
    logic [DW-1:0]    rf_dut   [32];

    typedef struct {
        logic          rst;
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          r0;
        logic          r1;
        logic          we;
        logic [AW-1:0] wn;
        logic [DW-1:0] wd;
        logic          s;
        logic [CW-1:0] conf;
    } vec_t;

    vec_t tbl [15];
    vec_t none_v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // 0 = no grant, 1 = req0, 2 = req1.
    function automatic int model_grant(input int k);
        if (rst) return 0;
        if (v0 && v1) return (m_wait[k] >= mw[k]) ? 2 : 1;
        if (v0) return 1;
        if (v1) return 2;
        return 0;
    endfunction

    task automatic model_update(input int k, input int g);
        if (rst) begin
            m_we[k] = 1'b0; m_wn[k] = '0; m_wd[k] = '0; m_s[k] = 1'b0;
            m_wait[k] = 0; m_conf[k] = 0;
        end else begin
            if (g == 1) begin
                m_we[k] = (a0 != 0); m_wn[k] = a0; m_wd[k] = d0; m_s[k] = 1'b0;
            end else if (g == 2) begin
                m_we[k] = (a1 != 0); m_wn[k] = a1; m_wd[k] = d1; m_s[k] = 1'b1;
            end else begin
                m_we[k] = 1'b0;
            end
            if (g == 2 || !v1) m_wait[k] = 0;
            else if (m_wait[k] < mw[k]) m_wait[k] = m_wait[k] + 1;
            if (v0 && v1 && m_conf[k] < CONF_MAX) m_conf[k] = m_conf[k] + 1;
            if (k == 0 && m_we[0]) begin
                exp_q.push_back({m_wn[0], m_wd[0]});
                rf_model[m_wn[0]] = m_wd[0];
            end
        end
    endtask

    // One clock: rdy checked at the falling edge, registered outputs just after the rising edge.
    task automatic step(input bit use_tbl, input vec_t v);
        int g [2];
        logic [AW+DW-1:0] got;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            g[k] = model_grant(k);
            chk($sformatf("rdy0[%0d]", k), 64'(rdy0_o[k]), 64'(g[k] == 1));
            chk($sformatf("rdy1[%0d]", k), 64'(rdy1_o[k]), 64'(g[k] == 2));
        end
        if (use_tbl) begin
            chk("tbl_rdy0", 64'(rdy0_o[0]), 64'(v.r0));
            chk("tbl_rdy1", 64'(rdy1_o[0]), 64'(v.r1));
        end
        last_g = g[0];
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k, g[k]);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("we[%0d]", k), 64'(we_o[k]), 64'(m_we[k]));
            chk($sformatf("wn[%0d]", k), 64'(wn_o[k]), 64'(m_wn[k]));
            chk($sformatf("wd[%0d]", k), 64'(wd_o[k]), 64'(m_wd[k]));
            chk($sformatf("s[%0d]", k), 64'(s_o[k]), 64'(m_s[k]));
            chk($sformatf("conflicts[%0d]", k), 64'(conf_o[k]), 64'(m_conf[k]));
        end
        if (use_tbl) begin
            chk("tbl_we", 64'(we_o[0]), 64'(v.we));
            chk("tbl_wn", 64'(wn_o[0]), 64'(v.wn));
            chk("tbl_wd", 64'(wd_o[0]), 64'(v.wd));
            chk("tbl_s", 64'(s_o[0]), 64'(v.s));
            chk("tbl_conflicts", 64'(conf_o[0]), 64'(v.conf));
        end
        if (we_o[0] === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_write at %0t: got write wn=%0d wd=%0h expected no write",
                         $time, wn_o[0], wd_o[0]);
            end else begin
                got = exp_q.pop_front();
                if ({wn_o[0], wd_o[0]} !== got) begin
                    n_fail++;
                    $display("FAIL sb_write at %0t: got %0h expected %0h", $time,
                             {wn_o[0], wd_o[0]}, got);
                end
                rf_dut[wn_o[0]] = wd_o[0];
            end
        end
    endtask

    task automatic drive(input logic r, input logic iv0, input logic [AW-1:0] ia0,
                         input logic [DW-1:0] id0, input logic iv1, input logic [AW-1:0] ia1,
                         input logic [DW-1:0] id1);
        rst = r; v0 = iv0; a0 = ia0; d0 = id0; v1 = iv1; a1 = ia1; d1 = id1;
    endtask

    initial begin
        logic          p0, p1;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] rd0, rd1;

        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_conf[k] = 0; m_we[k] = 0; m_wn[k] = '0; m_wd[k] = '0; m_s[k] = 0;
        end
        for (int i = 0; i < 32; i++) begin
            rf_model[i] = '0;
            rf_dut[i]   = '0;
        end
        none_v = '{default: '0};

        //          rst v0 a0  d0             v1 a1  d1            r0 r1 we wn  wd             s  conf
        tbl[0]  = '{1, 1, 3,  32'h1,         1, 4,  32'h2,        0, 0, 0, 0,  32'h0,        0, 0};
        tbl[1]  = '{1, 1, 3,  32'h1,         1, 4,  32'h2,        0, 0, 0, 0,  32'h0,        0, 0};
        tbl[2]  = '{0, 1, 5,  32'hA5A5_0001, 0, 4,  32'h2,        1, 0, 1, 5,  32'hA5A5_0001, 0, 0};
        tbl[3]  = '{0, 0, 5,  32'hA5A5_0001, 0, 4,  32'h2,        0, 0, 0, 5,  32'hA5A5_0001, 0, 0};
        tbl[4]  = '{0, 0, 5,  32'h0,         1, 0,  32'hFFFF_FFFF, 0, 1, 0, 0, 32'hFFFF_FFFF, 1, 0};
        tbl[5]  = '{0, 1, 5,  32'h1,         1, 12, 32'h2,        1, 0, 1, 5,  32'h1,        0, 1};
        tbl[6]  = '{0, 1, 5,  32'h1,         1, 12, 32'h2,        1, 0, 1, 5,  32'h1,        0, 2};
        tbl[7]  = '{0, 1, 5,  32'h1,         1, 12, 32'h2,        1, 0, 1, 5,  32'h1,        0, 3};
        tbl[8]  = '{0, 1, 5,  32'h1,         1, 12, 32'h2,        0, 1, 1, 12, 32'h2,        1, 4};
        tbl[9]  = '{0, 1, 5,  32'h1,         1, 12, 32'h2,        1, 0, 1, 5,  32'h1,        0, 5};
        tbl[10] = '{0, 0, 5,  32'h1,         0, 12, 32'h2,        0, 0, 0, 5,  32'h1,        0, 5};
        tbl[11] = '{0, 1, 7,  32'h3,         1, 9,  32'h4,        1, 0, 1, 7,  32'h3,        0, 6};
        tbl[12] = '{0, 1, 7,  32'h3,         1, 9,  32'h4,        1, 0, 1, 7,  32'h3,        0, 7};
        tbl[13] = '{1, 1, 7,  32'h3,         1, 9,  32'h4,        0, 0, 0, 0,  32'h0,        0, 0};
        tbl[14] = '{0, 1, 7,  32'h3,         1, 9,  32'h4,        1, 0, 1, 7,  32'h3,        0, 1};

        drive(1, 0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            step(1'b1, tbl[i]);
        end

        // Sustained conflict long enough to pin the statistics counter at all-ones.
        drive(1, 0, '0, '0, 0, '0, '0);
        step(1'b0, none_v);
        drive(0, 1, 5'd1, 32'h1111_0000, 1, 5'd2, 32'h2222_0000);
        for (int i = 0; i < CONF_MAX + 5; i++) step(1'b0, none_v);
        chk("conflicts_saturated", 64'(conf_o[0]), 64'(16'hFFFF));

        // Random requesters that hold until accepted, occasionally withdraw, rarely see reset.
        p0 = 0; p1 = 0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!p0) begin
                if ($urandom_range(0, 2) != 0) begin
                    p0 = 1; ra0 = AW'($urandom_range(0, 31)); rd0 = $urandom;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                p0 = 0;
            end
            if (!p1) begin
                if ($urandom_range(0, 2) != 0) begin
                    p1 = 1; ra1 = AW'($urandom_range(0, 31)); rd1 = $urandom;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                p1 = 0;
            end
            drive(rst, p0, ra0, rd0, p1, ra1, rd1);
            step(1'b0, none_v);
            if (rst) begin
                p0 = 0; p1 = 0;
            end else begin
                if (last_g == 1) p0 = 0;
                if (last_g == 2) p1 = 0;
            end
        end

        drive(0, 0, '0, '0, 0, '0, '0);
        step(1'b0, none_v);
        chk("sb_pending", 64'(exp_q.size()), 64'(0));
        for (int i = 0; i < 32; i++) chk($sformatf("regfile[%0d]", i), 64'(rf_dut[i]), 64'(rf_model[i]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
